rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 SHALL have parameter PTR_RST, default 3'd0: round-robin pointer value after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 8: request vector, bit i = requester i.
REQ-005 SHALL have port gnt_valid, output, 1: grant index is valid.
REQ-006 SHALL have port gnt_idx, output, 3: binary index of the granted requester, fed to the downstream 3-to-8 decoder.
REQ-007 SHALL have port gnt_ready, input, 1: downstream accepts the grant.
REQ-008 SHALL have port busy, output, 1: high in GRANT state.

Function
REQ-009 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-010 SHALL, in IDLE with effective req != 0, select the first set bit scanning circularly from ptr upward (ptr, ptr+1 ... 7, 0 ... ptr-1), register it into gnt_idx, set gnt_valid and enter GRANT; latency from req sampled to gnt_valid is 1 cycle.
REQ-011 SHALL, in IDLE with effective req == 0, hold gnt_valid=0 and remain in IDLE; gnt_idx holds its last value.
REQ-012 SHALL, in GRANT, hold gnt_idx and gnt_valid stable while gnt_ready=0, regardless of req changes, including deassertion of the granted bit.
REQ-013 SHALL, on gnt_valid & gnt_ready, load ptr <= gnt_idx + 1 modulo 8 (7 wraps to 0), clear gnt_valid and return to IDLE on the next edge.
REQ-014 SHALL deliver at most one grant per two cycles; no back-to-back grant without an intervening IDLE cycle.
REQ-015 SHALL ignore gnt_ready while in IDLE.
REQ-016 SHALL drive busy = 1 exactly when the state is GRANT.
REQ-017 SHALL leave ptr unchanged in every cycle without an accepted grant.

Reset
REQ-018 SHALL, with rst=1 at a clock edge, force state=IDLE, gnt_valid=0, gnt_idx=3'd0, busy=0, ptr=PTR_RST.
REQ-019 SHALL let rst take priority over every other event, including a simultaneous gnt_ready handshake; the aborted grant is discarded and ptr is not advanced.
REQ-020 SHALL evaluate requests starting from the first edge after rst deasserts.

Configuration
REQ-021 SHALL, with macro RR_ARB_MASK_EN defined, add input req_mask (8 bits), with effective req = req & ~req_mask, evaluated only in IDLE.
REQ-022 SHALL, without RR_ARB_MASK_EN, omit req_mask entirely and use effective req = req.

Structure
REQ-023 SHALL place NUM_REQ=8, IDX_W=3 and the FSM state enum (IDLE, GRANT) in shared package rr_arb_pkg.
REQ-024 SHALL implement the circular first-set search as combinational sub-module rr_pick (inputs: req vector, ptr; outputs: any, idx).

Verification
REQ-025 SHALL cover: rst held, then req=8'b0000_0001 with gnt_ready=1 -> gnt_valid=1, gnt_idx=0 one cycle later; ptr becomes 1 after the handshake.
REQ-026 SHALL cover: req=8'hFF held, gnt_ready=1 -> gnt_idx sequence 0,1,2,...,7,0 on alternate cycles (wrap-around).
REQ-027 SHALL cover: ptr=5, req=8'b0010_0100 -> gnt_idx=5; next grant gnt_idx=2.
REQ-028 SHALL cover: grant to index 3 with gnt_ready=0 for 4 cycles while req[3] drops -> gnt_idx stays 3 and gnt_valid stays 1 until gnt_ready=1.
REQ-029 SHALL cover: rst=1 coincident with gnt_valid & gnt_ready at gnt_idx=6 -> next cycle gnt_valid=0, gnt_idx=0, ptr=PTR_RST.
REQ-030 SHALL cover, with RR_ARB_MASK_EN: req=8'hFF, req_mask=8'hFE -> only gnt_idx=0 is granted, repeatedly.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and pointer helper for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Priority pointer after an accepted grant: one past the winner, wrapping 7 -> 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters, the arbiter and the downstream decoder.
// Optional req_mask exists only when RR_ARB_MASK_EN is defined.
//
// Handshake: gnt_valid/gnt_idx are held stable by the arbiter until the cycle
// gnt_valid & gnt_ready is seen at a rising edge; that edge completes the transfer.
interface rr_arbiter_8_if;
  import rr_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_ready;
  logic               busy;
`ifdef RR_ARB_MASK_EN
  logic [NUM_REQ-1:0] req_mask;
`endif

  modport slave (
    input  req,
    input  gnt_ready,
`ifdef RR_ARB_MASK_EN
    input  req_mask,
`endif
    output gnt_valid,
    output gnt_idx,
    output busy
  );

  modport master (
    output req,
    output gnt_ready,
`ifdef RR_ARB_MASK_EN
    output req_mask,
`endif
    input  gnt_valid,
    input  gnt_idx,
    input  busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational circular first-set search: scans ptr, ptr+1 ... wrapping, and
// reports the first requesting index.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a held grant until downstream accepts.
// Build option: RR_ARB_MASK_EN adds req_mask (effective req = req & ~req_mask).
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter logic [IDX_W-1:0] PTR_RST = 3'd0
) (
  input  logic             clk,
  input  logic             rst,
  rr_arbiter_8_if.slave    bus,
  output arb_state_e       state_dbg,
  output logic [IDX_W-1:0] ptr_dbg
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] req_eff;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

`ifdef RR_ARB_MASK_EN
  assign req_eff = bus.req & ~bus.req_mask;
`else
  assign req_eff = bus.req;
`endif

  rr_pick u_pick (
    .req (req_eff),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      ptr_q     <= PTR_RST;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  // Requests are only looked at in IDLE, so a grant is never re-decided while held.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = GRANT;
          gnt_idx_d = pick_idx;
        end
      end
      GRANT: begin
        if (bus.gnt_ready) begin
          state_d = IDLE;
          ptr_d   = next_ptr(gnt_idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.busy      = (state_q == GRANT);
  assign bus.gnt_idx   = gnt_idx_q;
  assign state_dbg     = state_q;
  assign ptr_dbg       = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: expected grant indices are queued when the
// requests are driven and popped when the grant appears.
module tb_rr_arbiter_8;
  import rr_arb_pkg::*;

  localparam logic [IDX_W-1:0] PTR_RST = 3'd0;

  logic             clk = 1'b0;
  logic             rst;
  arb_state_e       state_dbg;
  logic [IDX_W-1:0] ptr_dbg;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.PTR_RST(PTR_RST)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .ptr_dbg   (ptr_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [IDX_W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".valid"}, 8'(bus.gnt_valid), 8'd0);
    chk({tag, ".busy"},  8'(bus.busy),      8'd0);
  endtask

  task automatic check_grant(input string tag);
    logic [IDX_W-1:0] exp;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, ".valid"}, 8'(bus.gnt_valid), 8'd1);
      chk({tag, ".busy"},  8'(bus.busy),      8'd1);
      chk({tag, ".idx"},   8'(bus.gnt_idx),   8'(exp));
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.gnt_ready = 1'b0;
`ifdef RR_ARB_MASK_EN
    bus.req_mask  = '0;
`endif
    tick();
    tick();
    check_idle("reset");
    chk("reset.idx",   8'(bus.gnt_idx), 8'd0);
    chk("reset.ptr",   8'(ptr_dbg),     8'(PTR_RST));
    chk("reset.state", 8'(state_dbg),   8'(IDLE));

    // single requester, one-cycle latency, ptr advances after handshake
    rst           = 1'b0;
    bus.req       = 8'b0000_0001;
    bus.gnt_ready = 1'b1;
    exp_q.push_back(3'd0);
    tick();
    check_grant("first");
    bus.req = '0;
    tick();
    check_idle("first_done");
    chk("first.ptr", 8'(ptr_dbg), 8'd1);

    // all requesting: rotation with wrap, grants on alternate cycles
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(IDX_W'(k % 8));
      tick();
      check_grant("rotate");
      tick();
      check_idle("rotate_gap");
      chk("rotate.ptr", 8'(ptr_dbg), 8'((k + 1) % 8));
    end

    // move ptr to 5, then sparse requests 5 and 2
    bus.req = 8'h10;
    exp_q.push_back(3'd4);
    tick();
    check_grant("to_ptr5");
    tick();
    chk("ptr5", 8'(ptr_dbg), 8'd5);
    bus.req = 8'b0010_0100;
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd2);
    tick();
    check_grant("sparse_a");
    tick();
    check_idle("sparse_gap");
    tick();
    check_grant("sparse_b");
    tick();
    chk("sparse.ptr", 8'(ptr_dbg), 8'd3);

    // hold grant 3 under backpressure while its request drops
    bus.req       = 8'h08;
    bus.gnt_ready = 1'b0;
    exp_q.push_back(3'd3);
    tick();
    check_grant("hold");
    for (int k = 0; k < 4; k++) begin
      bus.req = 8'($urandom_range(0, 255)) & 8'hF7;
      tick();
      chk("hold.valid", 8'(bus.gnt_valid), 8'd1);
      chk("hold.idx",   8'(bus.gnt_idx),   8'd3);
      chk("hold.ptr",   8'(ptr_dbg),       8'd3);
    end
    bus.req       = '0;
    bus.gnt_ready = 1'b1;
    tick();
    check_idle("hold_done");
    chk("hold_done.idx", 8'(bus.gnt_idx), 8'd3);
    chk("hold_done.ptr", 8'(ptr_dbg),     8'd4);

    // idle with no requests ignores gnt_ready
    tick();
    check_idle("idle_ready");
    chk("idle_ready.ptr", 8'(ptr_dbg), 8'd4);
    bus.gnt_ready = 1'b0;
    tick();
    check_idle("idle_noready");

    // reset wins over a handshake on grant 6
    bus.req = 8'h40;
    exp_q.push_back(3'd6);
    tick();
    check_grant("pre_rst");
    rst           = 1'b1;
    bus.gnt_ready = 1'b1;
    tick();
    check_idle("rst_abort");
    chk("rst_abort.idx",   8'(bus.gnt_idx), 8'd0);
    chk("rst_abort.ptr",   8'(ptr_dbg),     8'(PTR_RST));
    chk("rst_abort.state", 8'(state_dbg),   8'(IDLE));
    rst     = 1'b0;
    bus.req = 8'hC0;
    exp_q.push_back(3'd6);
    tick();
    check_grant("post_rst");
    bus.req = '0;
    tick();
    check_idle("post_rst_done");

`ifdef RR_ARB_MASK_EN
    bus.req      = 8'hFF;
    bus.req_mask = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(3'd0);
      tick();
      check_grant("mask");
      tick();
      check_idle("mask_gap");
    end
    bus.req      = '0;
    bus.req_mask = '0;
`endif

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
